xbus_driver: RTL and testbench

XBUS_DRIVER -- requirements
Module: xbus_driver

---
 rtl/xbus_pkg.sv | 19 +
 rtl/xbus_res_slot.sv | 37 +++
 rtl/xbus_driver.sv | 196 +++++++++++++++++++
 tb/tb_xbus_driver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared definitions for the xbus driver: FSM state encoding, default tag width
// and the transaction counter increment helper.
package xbus_pkg;

   localparam int XBUS_TW = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT_V = 2'd2,
      ST_FLUSH  = 2'd3
   } xbus_state_e;

   // Free-running 16-bit count; rolls over from 0xFFFF to 0x0000.
   function automatic logic [15:0] xbus_cnt_inc(input logic [15:0] cnt);
      return cnt + 16'd1;
   endfunction

endpackage

// File: rtl/xbus_res_slot.sv
// One-entry result register with a valid/ready handshake towards the result consumer.
module xbus_res_slot
   import xbus_pkg::*;
#(
   parameter int PW = 32
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [PW-1:0] i_psum,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [PW-1:0] o_psum
);

   logic          r_valid;
   logic [PW-1:0] r_psum;

   // A load always wins over a consume in the same cycle; data holds until the next load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_psum  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_psum  <= i_psum;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_valid = r_valid;
   assign o_psum  = r_psum;

endmodule

// File: rtl/xbus_driver.sv
// Bus driver: issues one global-buffer word set to the multicasters and collects the
// returned psum. Optional WAIT_V watchdog enabled by defining XBUS_TIMEOUT_EN.
module xbus_driver
   import xbus_pkg::*;
#(
   parameter  int DATA_WIDTH     = 16,
   parameter  int NUM_COL        = int'(32'd1 << XBUS_TW),
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int TW             = $clog2(NUM_COL)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    glb_valid,
   output logic                    glb_ready,
   input  logic [DATA_WIDTH-1:0]   glb_ifmap,
   input  logic [DATA_WIDTH-1:0]   glb_fltr,
   input  logic [2*DATA_WIDTH-1:0] glb_psum,
   input  logic [TW-1:0]           glb_tag,
   input  logic                    cfg_load,
   input  logic [7:0]              cfg_kernel_size,
   input  logic [TW-1:0]           cfg_id,
   output logic [DATA_WIDTH-1:0]   ifmap_data_B2M,
   output logic [DATA_WIDTH-1:0]   fltr_data_B2M,
   output logic [2*DATA_WIDTH-1:0] psum_data_B2M,
   input  logic [2*DATA_WIDTH-1:0] psum_data_M2B,
   output logic                    CASTER_EN,
   output logic                    READY,
   input  logic                    VALID,
   output logic [TW-1:0]           ID,
   output logic [TW-1:0]           TAG,
   output logic [7:0]              kernel_size,
   input  logic                    flush,
   input  logic                    flush_BUSY,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [2*DATA_WIDTH-1:0] res_psum,
   output logic [15:0]             txn_count,
   output logic                    err_timeout
);

   // The watchdog counter is 8 bits wide, so the limit must fit in 1..256.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("xbus_driver: TIMEOUT_CYCLES out of range");
   end

   xbus_state_e             r_state;
   xbus_state_e             w_next_state;
   logic [DATA_WIDTH-1:0]   r_ifmap;
   logic [DATA_WIDTH-1:0]   r_fltr;
   logic [2*DATA_WIDTH-1:0] r_psum;
   logic [TW-1:0]           r_tag;
   logic [TW-1:0]           r_id;
   logic [7:0]              r_kernel_size;
   logic [15:0]             r_txn_count;
   logic                    w_in_idle;
   logic                    w_accept;
   logic                    w_res_load;
   logic                    w_res_valid;
   logic                    w_wd_fire;

   assign w_in_idle  = (r_state == ST_IDLE);
   assign glb_ready  = w_in_idle & ~flush & ~flush_BUSY & (~w_res_valid | res_ready);
   assign w_accept   = glb_valid & glb_ready;
   // flush beats a coincident VALID: the returned psum is dropped.
   assign w_res_load = (r_state == ST_WAIT_V) & VALID & ~flush;

`ifdef XBUS_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_wd_cnt;
   logic       r_err_timeout;

   assign w_wd_fire = (r_state == ST_WAIT_V) & ~VALID & ~flush & (r_wd_cnt == WD_LAST);

   // Counts consecutive WAIT_V cycles; restarts from zero on every entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wd_cnt <= 8'd0;
      end else if (r_state == ST_WAIT_V) begin
         r_wd_cnt <= r_wd_cnt + 8'd1;
      end else begin
         r_wd_cnt <= 8'd0;
      end
   end

   // Sticky watchdog flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_timeout <= 1'b0;
      end else if (w_wd_fire) begin
         r_err_timeout <= 1'b1;
      end else begin
         r_err_timeout <= r_err_timeout;
      end
   end

   assign err_timeout = r_err_timeout;
`else
   assign w_wd_fire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Next-state decode; flush overrides every state.
   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = ST_FLUSH;
      end else begin
         case (r_state)
            ST_IDLE:   w_next_state = w_accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  w_next_state = ST_WAIT_V;
            ST_WAIT_V: w_next_state = (VALID | w_wd_fire) ? ST_IDLE : ST_WAIT_V;
            ST_FLUSH:  w_next_state = flush_BUSY ? ST_FLUSH : ST_IDLE;
            default:   w_next_state = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Transaction registers double as the held *_B2M / TAG outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ifmap <= '0;
         r_fltr  <= '0;
         r_psum  <= '0;
         r_tag   <= '0;
      end else if (w_accept) begin
         r_ifmap <= glb_ifmap;
         r_fltr  <= glb_fltr;
         r_psum  <= glb_psum;
         r_tag   <= glb_tag;
      end else begin
         r_ifmap <= r_ifmap;
         r_fltr  <= r_fltr;
         r_psum  <= r_psum;
         r_tag   <= r_tag;
      end
   end

   // Configuration is only taken while idle and not accepting a word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_kernel_size <= 8'd0;
         r_id          <= '0;
      end else if (cfg_load && w_in_idle && !w_accept) begin
         r_kernel_size <= cfg_kernel_size;
         r_id          <= cfg_id;
      end else begin
         r_kernel_size <= r_kernel_size;
         r_id          <= r_id;
      end
   end

   // Completed-transaction counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_txn_count <= 16'd0;
      end else if (w_res_load) begin
         r_txn_count <= xbus_cnt_inc(r_txn_count);
      end else begin
         r_txn_count <= r_txn_count;
      end
   end

   xbus_res_slot #(
      .PW (2*DATA_WIDTH)
   ) u_res_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_res_load),
      .i_psum  (psum_data_M2B),
      .i_ready (res_ready),
      .o_valid (w_res_valid),
      .o_psum  (res_psum)
   );

   assign res_valid      = w_res_valid;
   assign ifmap_data_B2M = r_ifmap;
   assign fltr_data_B2M  = r_fltr;
   assign psum_data_B2M  = r_psum;
   assign TAG            = r_tag;
   assign ID             = r_id;
   assign kernel_size    = r_kernel_size;
   assign txn_count      = r_txn_count;
   assign CASTER_EN      = (r_state == ST_ISSUE);
   assign READY          = (r_state == ST_WAIT_V);

endmodule

// File: tb/tb_xbus_driver.sv
// Directed bench for xbus_driver with a scoreboard on the result port.
// Timeout scenario is built when XBUS_TIMEOUT_EN is defined.
module tb_xbus_driver;

   localparam int DW = 16;
   localparam int TW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            glb_valid, glb_ready;
   logic [DW-1:0]   glb_ifmap, glb_fltr;
   logic [2*DW-1:0] glb_psum;
   logic [TW-1:0]   glb_tag;
   logic            cfg_load;
   logic [7:0]      cfg_kernel_size;
   logic [TW-1:0]   cfg_id;
   logic [DW-1:0]   ifmap_data_B2M, fltr_data_B2M;
   logic [2*DW-1:0] psum_data_B2M, psum_data_M2B;
   logic            CASTER_EN, READY, VALID;
   logic [TW-1:0]   ID, TAG;
   logic [7:0]      kernel_size;
   logic            flush, flush_BUSY;
   logic            res_valid, res_ready;
   logic [2*DW-1:0] res_psum;
   logic [15:0]     txn_count;
   logic            err_timeout;

   int              n_tests = 0;
   int              n_fail  = 0;
   int              cyc     = 0;
   int              hs_cyc;
   logic [15:0]     exp_cnt;
   logic [2*DW-1:0] sb_q[$];

   xbus_driver #(
      .DATA_WIDTH     (DW),
      .NUM_COL        (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .glb_valid (glb_valid), .glb_ready (glb_ready),
      .glb_ifmap (glb_ifmap), .glb_fltr (glb_fltr), .glb_psum (glb_psum), .glb_tag (glb_tag),
      .cfg_load (cfg_load), .cfg_kernel_size (cfg_kernel_size), .cfg_id (cfg_id),
      .ifmap_data_B2M (ifmap_data_B2M), .fltr_data_B2M (fltr_data_B2M),
      .psum_data_B2M (psum_data_B2M), .psum_data_M2B (psum_data_M2B),
      .CASTER_EN (CASTER_EN), .READY (READY), .VALID (VALID),
      .ID (ID), .TAG (TAG), .kernel_size (kernel_size),
      .flush (flush), .flush_BUSY (flush_BUSY),
      .res_valid (res_valid), .res_ready (res_ready), .res_psum (res_psum),
      .txn_count (txn_count), .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted result must match the oldest expected psum.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_unexpected_result", 64'(res_psum), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check_eq("sb_res_psum", 64'(res_psum), 64'(sb_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "simulation time limit");
   end

   // Drives a word, waits (bounded) for the handshake, checks ISSUE and entry to WAIT_V.
   // Returns at the first WAIT_V cycle.
   task automatic start_txn(input logic [TW-1:0] tg, input logic [DW-1:0] ifm,
                            input logic [DW-1:0] flt, input logic [2*DW-1:0] ps);
      int n = 0;
      glb_valid = 1'b1; glb_tag = tg; glb_ifmap = ifm; glb_fltr = flt; glb_psum = ps;
      #1;
      while (!glb_ready && n < 40) begin
         @(negedge clk); #1; n++;
      end
      check_eq("hs_ready", 64'(glb_ready), 64'd1);
      check_eq("pre_caster_off", 64'(CASTER_EN), 64'd0);
      hs_cyc = cyc;
      @(negedge clk);
      glb_valid = 1'b0; glb_ifmap = ~ifm; glb_fltr = ~flt; glb_psum = ~ps; glb_tag = ~tg;
      #1;
      check_eq("issue_caster_on", 64'(CASTER_EN), 64'd1);
      check_eq("issue_tag", 64'(TAG), 64'(tg));
      check_eq("issue_ifmap", 64'(ifmap_data_B2M), 64'(ifm));
      check_eq("issue_fltr", 64'(fltr_data_B2M), 64'(flt));
      check_eq("issue_psum", 64'(psum_data_B2M), 64'(ps));
      check_eq("issue_ready_off", 64'(READY), 64'd0);
      @(negedge clk); #1;
      check_eq("wait_caster_off", 64'(CASTER_EN), 64'd0);
      check_eq("wait_ready_on", 64'(READY), 64'd1);
      check_eq("wait_ifmap_hold", 64'(ifmap_data_B2M), 64'(ifm));
   endtask

   // Returns the psum from the multicaster and checks the result one cycle later.
   task automatic finish_txn(input logic [2*DW-1:0] m2b);
      VALID = 1'b1; psum_data_M2B = m2b;
      sb_q.push_back(m2b);
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      VALID = 1'b0; psum_data_M2B = ~m2b;
      #1;
      check_eq("res_valid_set", 64'(res_valid), 64'd1);
      check_eq("res_psum", 64'(res_psum), 64'(m2b));
      check_eq("txn_count", 64'(txn_count), 64'(exp_cnt));
      check_eq("ready_after_valid", 64'(READY), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; glb_valid = 1'b0; glb_ifmap = '0; glb_fltr = '0; glb_psum = '0;
      glb_tag = '0; cfg_load = 1'b0; cfg_kernel_size = 8'd0; cfg_id = '0;
      psum_data_M2B = '0; VALID = 1'b0; flush = 1'b0; flush_BUSY = 1'b0;
      res_ready = 1'b1; exp_cnt = 16'd0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_txn_count", 64'(txn_count), 64'd0);
      check_eq("rst_res_valid", 64'(res_valid), 64'd0);
      check_eq("rst_kernel_size", 64'(kernel_size), 64'd0);
      check_eq("rst_id", 64'(ID), 64'd0);
      check_eq("rst_err_timeout", 64'(err_timeout), 64'd0);
      check_eq("rst_caster", 64'(CASTER_EN), 64'd0);
      check_eq("rst_ready", 64'(READY), 64'd0);
      check_eq("rst_tag", 64'(TAG), 64'd0);
      rst_n = 1'b1;

      // Basic: handshake in cycle 10, VALID in cycle 12, result in cycle 13
      while (cyc != 10) @(negedge clk);
      #1;
      check_eq("idle_glb_ready", 64'(glb_ready), 64'd1);
      start_txn(2'd2, 16'h0011, 16'h0022, 32'h0);
      check_eq("basic_hs_cycle", 64'(hs_cyc), 64'd10);
      check_eq("basic_valid_cycle", 64'(cyc), 64'd12);
      finish_txn(32'h0000_1234);
      check_eq("basic_res_cycle", 64'(cyc), 64'd13);

      // VALID outside WAIT_V is ignored
      @(negedge clk); #1;
      VALID = 1'b1; psum_data_M2B = 32'h5A5A_5A5A;
      repeat (2) @(negedge clk);
      #1;
      VALID = 1'b0;
      check_eq("idle_valid_ignored", 64'(res_valid), 64'd0);
      check_eq("idle_valid_cnt", 64'(txn_count), 64'(exp_cnt));

      // Backpressure: held result blocks the next upstream word
      res_ready = 1'b0;
      start_txn(2'd1, 16'h1111, 16'h2222, 32'h3333_4444);
      finish_txn(32'hAAAA_5555);
      glb_valid = 1'b1; glb_tag = 2'd3; glb_ifmap = 16'hBEEF;
      glb_fltr = 16'hCAFE; glb_psum = 32'h0102_0304;
      repeat (4) begin
         #1;
         check_eq("bp_glb_ready_low", 64'(glb_ready), 64'd0);
         check_eq("bp_res_psum_hold", 64'(res_psum), 64'hAAAA_5555);
         check_eq("bp_res_valid_hold", 64'(res_valid), 64'd1);
         @(negedge clk);
      end
      #1;
      res_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", 64'(glb_ready), 64'd1);
      start_txn(2'd3, 16'hBEEF, 16'hCAFE, 32'h0102_0304);
      finish_txn(32'h0BAD_F00D);

      // Flush during WAIT_V with a coincident VALID
      @(negedge clk); #1;
      start_txn(2'd0, 16'h0F0F, 16'hF0F0, 32'h1357_9BDF);
      VALID = 1'b1; psum_data_M2B = 32'hDEAD_0001; flush = 1'b1;
      @(negedge clk);
      VALID = 1'b0; flush = 1'b0; flush_BUSY = 1'b1;
      #1;
      check_eq("flush_res_valid", 64'(res_valid), 64'd0);
      check_eq("flush_txn_count", 64'(txn_count), 64'(exp_cnt));
      check_eq("flush_ready_off", 64'(READY), 64'd0);
      check_eq("flush_caster_off", 64'(CASTER_EN), 64'd0);
      for (int i = 0; i < 3; i++) begin
         check_eq("flush_busy_glb_ready", 64'(glb_ready), 64'd0);
         @(negedge clk); #1;
      end
      flush_BUSY = 1'b0;
      #1;
      check_eq("flush_exit_glb_ready", 64'(glb_ready), 64'd0);
      @(negedge clk); #1;
      check_eq("flush_idle_glb_ready", 64'(glb_ready), 64'd1);
      check_eq("flush_no_result", 64'(res_valid), 64'd0);

      // Config load in IDLE, then ignored with a handshake and in WAIT_V
      cfg_load = 1'b1; cfg_kernel_size = 8'd3; cfg_id = 2'd1;
      @(negedge clk);
      cfg_load = 1'b0;
      #1;
      check_eq("cfg_kernel_size", 64'(kernel_size), 64'd3);
      check_eq("cfg_id", 64'(ID), 64'd1);
      cfg_load = 1'b1; cfg_kernel_size = 8'd7; cfg_id = 2'd2;
      start_txn(2'd1, 16'h0A0A, 16'h0B0B, 32'h0C0C_0C0C);
      cfg_kernel_size = 8'd9; cfg_id = 2'd3;
      @(negedge clk); #1;
      cfg_load = 1'b0;
      check_eq("cfg_wait_kernel_size", 64'(kernel_size), 64'd3);
      check_eq("cfg_wait_id", 64'(ID), 64'd1);
      finish_txn(32'h7777_8888);

      // Wrap: counter preloaded near the top, then two real transactions
      @(negedge clk);
      force dut.r_txn_count = 16'hFFFE;
      @(negedge clk);
      release dut.r_txn_count;
      exp_cnt = 16'hFFFE;
      #1;
      check_eq("wrap_preload", 64'(txn_count), 64'hFFFE);
      start_txn(2'd2, 16'h1234, 16'h5678, 32'h9ABC_DEF0);
      finish_txn(32'h0000_FFFF);
      start_txn(2'd3, 16'h4321, 16'h8765, 32'h0FED_CBA9);
      finish_txn(32'h0001_0000);
      check_eq("wrap_zero", 64'(txn_count), 64'h0000);

`ifdef XBUS_TIMEOUT_EN
      // Watchdog: 8 WAIT_V cycles without VALID
      @(negedge clk); #1;
      start_txn(2'd1, 16'h2468, 16'h1357, 32'h1111_2222);
      check_eq("wd_err_clear", 64'(err_timeout), 64'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); #1;
         check_eq("wd_still_waiting", 64'(READY), 64'd1);
         check_eq("wd_err_not_yet", 64'(err_timeout), 64'd0);
      end
      @(negedge clk); #1;
      check_eq("wd_err_set", 64'(err_timeout), 64'd1);
      check_eq("wd_ready_off", 64'(READY), 64'd0);
      check_eq("wd_glb_ready", 64'(glb_ready), 64'd1);
      check_eq("wd_no_result", 64'(res_valid), 64'd0);
      check_eq("wd_txn_count", 64'(txn_count), 64'(exp_cnt));
      repeat (3) @(negedge clk);
      #1;
      check_eq("wd_err_sticky", 64'(err_timeout), 64'd1);
`else
      // Without the watchdog WAIT_V waits indefinitely
      @(negedge clk); #1;
      start_txn(2'd1, 16'h2468, 16'h1357, 32'h1111_2222);
      repeat (20) @(negedge clk);
      #1;
      check_eq("nowd_still_waiting", 64'(READY), 64'd1);
      check_eq("nowd_err_low", 64'(err_timeout), 64'd0);
      finish_txn(32'h2222_3333);
`endif

      // Reset mid-transaction: no result, everything cleared
      @(negedge clk); #1;
      cfg_load = 1'b1; cfg_kernel_size = 8'd5; cfg_id = 2'd2;
      @(negedge clk); #1;
      cfg_load = 1'b0;
      start_txn(2'd2, 16'h9999, 16'h8888, 32'h7777_6666);
      rst_n = 1'b0; VALID = 1'b1; psum_data_M2B = 32'h4444_4444;
      @(negedge clk);
      rst_n = 1'b1; VALID = 1'b0;
      exp_cnt = 16'd0;
      #1;
      check_eq("mid_rst_res_valid", 64'(res_valid), 64'd0);
      check_eq("mid_rst_txn_count", 64'(txn_count), 64'd0);
      check_eq("mid_rst_kernel_size", 64'(kernel_size), 64'd0);
      check_eq("mid_rst_id", 64'(ID), 64'd0);
      check_eq("mid_rst_ready", 64'(READY), 64'd0);
      check_eq("mid_rst_ifmap", 64'(ifmap_data_B2M), 64'd0);
      check_eq("mid_rst_err", 64'(err_timeout), 64'd0);
      @(negedge clk); #1;
      check_eq("post_rst_no_result", 64'(res_valid), 64'd0);
      start_txn(2'd1, 16'h0001, 16'h0002, 32'h0000_0003);
      finish_txn(32'h0000_00AB);

      repeat (3) @(negedge clk);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
